// File: rtl/rtype_instr_encoder_if.sv
// rtl/rtype_instr_encoder_if.sv - request/response bundle for the R-type instruction encoder
interface rtype_instr_encoder_if #(
   parameter int INSTR_WIDTH  = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int DEPTH        = 4,
   parameter int FW           = $clog2(DEPTH + 1)
);
   logic                    in_valid;
   logic                    in_ready;
   logic [ALU_OP_WIDTH-1:0] alu_op;
   logic [4:0]              rd;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic                    out_valid;
   logic                    out_ready;
   logic [INSTR_WIDTH-1:0]  instruction;
   logic                    illegal_err;
   logic [7:0]              err_count;
   logic [FW-1:0]           fill_level;

   modport master (
      output in_valid, alu_op, rd, rs1, rs2, out_ready,
      input  in_ready, out_valid, instruction, illegal_err, err_count, fill_level
   );

   modport slave (
      input  in_valid, alu_op, rd, rs1, rs2, out_ready,
      output in_ready, out_valid, instruction, illegal_err, err_count, fill_level
   );
endinterface

// File: rtl/rtype_instr_encoder.sv
// rtl/rtype_instr_encoder.sv - alu_op + register indices to RV32I R-type word, FIFO buffered
module rtype_instr_encoder #(
   parameter int INSTR_WIDTH  = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int DEPTH        = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rtype_instr_encoder_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] DEPTH_L = FW'(DEPTH);
   localparam logic [6:0]    OPCODE  = 7'b0110011;

   logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [FW-1:0]          r_fill;
   logic                   r_live;
   logic                   r_illegal;
   logic [7:0]             r_err_cnt;

   logic [2:0]             w_func3;
   logic [6:0]             w_func7;
   logic                   w_legal;
   logic [INSTR_WIDTH-1:0] w_word;
   logic                   w_in_ready;
   logic                   w_out_valid;
   logic                   w_accept;
   logic                   w_push;
   logic                   w_pop;

   // r_live keeps in_ready low until the first edge after reset release
   assign w_in_ready  = r_live && (r_fill < DEPTH_L);
   assign w_out_valid = (r_fill != '0);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_push      = w_accept && w_legal;
   assign w_pop       = w_out_valid && bus.out_ready;

   // Map alu_op to func3/func7; codes outside 0..9 are flagged illegal
   always_comb begin
      w_func3 = 3'b000;
      w_func7 = 7'b0000000;
      w_legal = 1'b1;
      case (bus.alu_op)
         ALU_OP_WIDTH'(0): begin w_func3 = 3'b000; end
         ALU_OP_WIDTH'(1): begin w_func3 = 3'b000; w_func7 = 7'b0100000; end
         ALU_OP_WIDTH'(2): begin w_func3 = 3'b001; end
         ALU_OP_WIDTH'(3): begin w_func3 = 3'b010; end
         ALU_OP_WIDTH'(4): begin w_func3 = 3'b011; end
         ALU_OP_WIDTH'(5): begin w_func3 = 3'b100; end
         ALU_OP_WIDTH'(6): begin w_func3 = 3'b101; end
         ALU_OP_WIDTH'(7): begin w_func3 = 3'b101; w_func7 = 7'b0100000; end
         ALU_OP_WIDTH'(8): begin w_func3 = 3'b110; end
         ALU_OP_WIDTH'(9): begin w_func3 = 3'b111; end
         default:          begin w_legal = 1'b0; end
      endcase
   end

   assign w_word = {w_func7, bus.rs2, bus.rs1, w_func3, bus.rd, OPCODE};

   // FIFO storage: write the encoded word at the tail on a legal accept
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // Pointers, occupancy and the post-reset enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_live   <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + FW'(1);
            2'b01:   r_fill <= r_fill - FW'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Illegal-op pulse and saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_illegal <= w_accept && !w_legal;
         if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // Head word is forced to zero when empty so reset shows a clean output
   assign bus.instruction = w_out_valid ? r_mem[r_rd_ptr] : '0;
   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.fill_level  = r_fill;
   assign bus.illegal_err = r_illegal;
   assign bus.err_count   = r_err_cnt;
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb/tb_rtype_instr_encoder.sv - randomized self-checking bench for rtype_instr_encoder
module tb_rtype_instr_encoder;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rtype_instr_encoder_if #(.DEPTH(DEPTH)) bus ();
   rtype_instr_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q_word[$];
   int          q_op[$];
   bit          m_live;
   bit          m_pend;
   int          m_errs;

   int f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
   int f7_tab [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1, input int rs2);
      int w;
      w = f7_tab[op] * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
        + f3_tab[op] * (1 << 12) + rd * (1 << 7) + 51;
      return 32'(w);
   endfunction

   function automatic int ref_decode(input logic [31:0] w);
      int opc;
      int f3;
      int f7;
      opc = int'(w) & 127;
      f3  = (int'(w) >>> 12) & 7;
      f7  = int'(w >> 25);
      for (int k = 0; k < 10; k++) begin
         if (opc == 51 && f3 == f3_tab[k] && f7 == f7_tab[k]) return k;
      end
      return 15;
   endfunction

   task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2, input bit ordy);
      bit acc;
      bit pop;
      logic [3:0] op4;
      op4 = op[3:0];
      bus.in_valid  = v;
      bus.alu_op    = op4;
      bus.rd        = rd[4:0];
      bus.rs1       = rs1[4:0];
      bus.rs2       = rs2[4:0];
      bus.out_ready = ordy;
      #1;
      chk("in_ready",    32'(bus.in_ready),    32'(m_live && q_word.size() < DEPTH));
      chk("out_valid",   32'(bus.out_valid),   32'(q_word.size() != 0));
      chk("fill_level",  32'(bus.fill_level),  32'(q_word.size()));
      chk("illegal_err", 32'(bus.illegal_err), 32'(m_pend));
      chk("err_count",   32'(bus.err_count),   32'(m_errs));
      if (q_word.size() != 0) begin
         chk("instruction", bus.instruction, q_word[0]);
         chk("round_trip", 32'(ref_decode(bus.instruction)), 32'(q_op[0]));
      end
      acc = v && m_live && (q_word.size() < DEPTH);
      pop = ordy && (q_word.size() != 0);
      @(posedge clk);
      if (pop) begin
         void'(q_word.pop_front());
         void'(q_op.pop_front());
      end
      m_pend = acc && (op >= 10);
      if (acc && op < 10) begin
         q_word.push_back(ref_encode(op, rd, rs1, rs2));
         q_op.push_back(op);
      end
      if (m_pend && m_errs < 255) m_errs++;
      m_live = (rst_n === 1'b1);
      #1;
   endtask

   task automatic rnd_legal(input bit ordy);
      step(1'b1, int'($urandom_range(0, 9)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), ordy);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.alu_op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.out_ready = 1'b0;
      m_live = 1'b0; m_pend = 1'b0; m_errs = 0;
      #12;
      chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_instr",     bus.instruction, 32'd0);
      chk("rst_fill",      32'(bus.fill_level), 32'd0);
      chk("rst_err_count", 32'(bus.err_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 0, 0, 0, 0, 1'b0);

      // single add with out_ready high
      step(1'b1, 0, 3, 1, 2, 1'b1);
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_word",  bus.instruction, 32'h002081B3);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 1'b1);

      // three back-to-back, then drain in order
      step(1'b1, 1, 5, 6, 7, 1'b0);
      step(1'b1, 7, 10, 11, 12, 1'b0);
      step(1'b1, 9, 1, 2, 3, 1'b0);
      chk("three_fill", 32'(bus.fill_level), 32'd3);
      chk("sub_word", bus.instruction, 32'h407302B3);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("sra_word", bus.instruction, 32'h40C5D533);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("and_word", bus.instruction, 32'h003170B3);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 1'b0);

      // overfill, pop one, drain across wrap
      for (int i = 0; i < DEPTH + 2; i++) rnd_legal(1'b0);
      chk("full_fill",  32'(bus.fill_level), 32'(DEPTH));
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 2, 4, 4, 4, 1'b1);
      chk("refill_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 0, 0, 0, 0, 1'b1);

      // illegal op and saturation
      step(1'b1, 12, 1, 1, 1, 1'b1);
      chk("illegal_pulse", 32'(bus.illegal_err), 32'd1);
      chk("illegal_count", 32'(bus.err_count), 32'd1);
      chk("illegal_fill",  32'(bus.fill_level), 32'd0);
      for (int i = 0; i < 300; i++)
         step(1'b1, int'($urandom_range(10, 15)), int'($urandom_range(0, 31)), 1, 2, 1'(($urandom) & 1));
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("err_saturated", 32'(bus.err_count), 32'd255);

      // sustained stream
      for (int i = 0; i < 64; i++) rnd_legal(1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 0, 1'b1);

      // random mix
      for (int i = 0; i < 300; i++)
         step(1'(($urandom) & 1), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'(($urandom_range(0, 3)) != 0));

      // reset mid-stream with entries queued
      for (int i = 0; i < 3; i++) rnd_legal(1'b0);
      step(1'b1, 11, 0, 0, 0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_fill",  32'(bus.fill_level), 32'd0);
      chk("mid_rst_err",   32'(bus.err_count), 32'd0);
      chk("mid_rst_pulse", 32'(bus.illegal_err), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      q_word.delete(); q_op.delete();
      m_live = 1'b0; m_pend = 1'b0; m_errs = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 30; i++)
         step(1'(($urandom) & 1), int'($urandom_range(0, 12)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'(($urandom) & 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
